// File: rtl/div_pipe_arbiter.sv
// Round-robin front end sharing one pipelined signed divider between two requesters.
// Issue strobe one cycle after ack; done LATENCIA+2 cycles after ack; a port holding an unread result is not granted.
module div_pipe_arbiter #(
   parameter int ANCHO_DV = 16,
   parameter int ANCHO_DD = 32,
   parameter int ANCHO_Q  = 16,
   parameter int LATENCIA = 18
) (
   input  logic                clk,
   input  logic                reset,
   input  logic                req0,
   input  logic                req1,
   input  logic [ANCHO_DV-1:0] divisor0,
   input  logic [ANCHO_DV-1:0] divisor1,
   input  logic [ANCHO_DD-1:0] dividend0,
   input  logic [ANCHO_DD-1:0] dividend1,
   output logic                ack0,
   output logic                ack1,
   output logic                done0,
   output logic                done1,
   output logic [ANCHO_Q-1:0]  quotient0,
   output logic [ANCHO_Q-1:0]  quotient1,
   output logic [ANCHO_Q-1:0]  remainder0,
   output logic [ANCHO_Q-1:0]  remainder1,
   output logic                divzero0,
   output logic                divzero1,
   input  logic                rd0,
   input  logic                rd1,
   output logic                goPipe,
   output logic [ANCHO_DV-1:0] divisorPipe,
   output logic [ANCHO_DD-1:0] dividendPipe,
   input  logic                goResult,
   input  logic [ANCHO_Q-1:0]  quotientResult,
   input  logic [ANCHO_Q-1:0]  remainderResult,
   input  logic                divisorNoCeroResult,
   output logic                err
);

   logic                inflight0, inflight1;
   logic                ptr;
   logic                owner;
   logic [LATENCIA-1:0] tagValid;
   logic [LATENCIA-1:0] tagId;
   logic                elig0, elig1;
   logic                headValid, headId;

   assign elig0 = req0 && !inflight0 && !done0;
   assign elig1 = req1 && !inflight1 && !done1;
   assign ack0  = !reset && elig0 && (!elig1 || !ptr);
   assign ack1  = !reset && elig1 && (!elig0 || ptr);

   // goPipe/owner act as the stage feeding the tag register, so the last
   // entry lines up with goResult LATENCIA cycles after goPipe.
   assign headValid = tagValid[LATENCIA-1];
   assign headId    = tagId[LATENCIA-1];

   always_ff @(posedge clk) begin
      if (reset) begin
         goPipe       <= 1'b0;
         divisorPipe  <= '0;
         dividendPipe <= '0;
         owner        <= 1'b0;
         ptr          <= 1'b0;
         tagValid     <= '0;
         tagId        <= '0;
         inflight0    <= 1'b0;
         inflight1    <= 1'b0;
         done0        <= 1'b0;
         done1        <= 1'b0;
         quotient0    <= '0;
         quotient1    <= '0;
         remainder0   <= '0;
         remainder1   <= '0;
         divzero0     <= 1'b0;
         divzero1     <= 1'b0;
         err          <= 1'b0;
      end else begin
         goPipe   <= ack0 || ack1;
         tagValid <= {tagValid[LATENCIA-2:0], goPipe};
         tagId    <= {tagId[LATENCIA-2:0], owner};
         if (ack0 || ack1) begin
            owner        <= ack1;
            ptr          <= ~ack1;
            divisorPipe  <= ack1 ? divisor1 : divisor0;
            dividendPipe <= ack1 ? dividend1 : dividend0;
         end

         if (rd0 && done0) done0 <= 1'b0;
         if (rd1 && done1) done1 <= 1'b0;

         // A valid head always retires its owner, even without a result.
         if (headValid && !headId) inflight0 <= 1'b0;
         if (headValid && headId)  inflight1 <= 1'b0;
         if (ack0) inflight0 <= 1'b1;
         if (ack1) inflight1 <= 1'b1;

         if (headValid && goResult) begin
            if (!headId) begin
               quotient0  <= quotientResult;
               remainder0 <= remainderResult;
               divzero0   <= ~divisorNoCeroResult;
               done0      <= 1'b1;
            end else begin
               quotient1  <= quotientResult;
               remainder1 <= remainderResult;
               divzero1   <= ~divisorNoCeroResult;
               done1      <= 1'b1;
            end
         end

         if (headValid != goResult) err <= 1'b1;
      end
   end

endmodule

// File: tb/tb_div_pipe_arbiter.sv
// Directed bench for div_pipe_arbiter with a behavioural divider pipeline behind it.
module tb_div_pipe_arbiter;
   localparam int L = 18;

   logic        clk = 1'b0;
   logic        reset;
   logic        req0, req1, rd0, rd1;
   logic [15:0] divisor0, divisor1;
   logic [31:0] dividend0, dividend1;
   logic        ack0, ack1, done0, done1, divzero0, divzero1;
   logic [15:0] quotient0, quotient1, remainder0, remainder1;
   logic        goPipe, goResult, divisorNoCeroResult, err;
   logic [15:0] divisorPipe, quotientResult, remainderResult;
   logic [31:0] dividendPipe;
   logic        forceGo;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   div_pipe_arbiter #(.ANCHO_DV(16), .ANCHO_DD(32), .ANCHO_Q(16), .LATENCIA(L)) dut (
      .clk(clk), .reset(reset),
      .req0(req0), .req1(req1),
      .divisor0(divisor0), .divisor1(divisor1),
      .dividend0(dividend0), .dividend1(dividend1),
      .ack0(ack0), .ack1(ack1), .done0(done0), .done1(done1),
      .quotient0(quotient0), .quotient1(quotient1),
      .remainder0(remainder0), .remainder1(remainder1),
      .divzero0(divzero0), .divzero1(divzero1),
      .rd0(rd0), .rd1(rd1),
      .goPipe(goPipe), .divisorPipe(divisorPipe), .dividendPipe(dividendPipe),
      .goResult(goResult), .quotientResult(quotientResult),
      .remainderResult(remainderResult), .divisorNoCeroResult(divisorNoCeroResult),
      .err(err)
   );

   // Divider stand-in: goPipe to goResult takes exactly L cycles.
   function automatic logic [15:0] divQ(logic [31:0] dd, logic [15:0] dv);
      logic signed [31:0] a, b;
      a = dd;
      b = {{16{dv[15]}}, dv};
      if (dv == 16'd0) return 16'd0;
      return 16'(a / b);
   endfunction

   function automatic logic [15:0] divR(logic [31:0] dd, logic [15:0] dv);
      logic signed [31:0] a, b;
      a = dd;
      b = {{16{dv[15]}}, dv};
      if (dv == 16'd0) return 16'd0;
      return 16'(a % b);
   endfunction

   logic [L-1:0] mV;
   logic [15:0]  mQ [L];
   logic [15:0]  mR [L];
   logic         mNz [L];

   always @(posedge clk) begin
      if (reset) begin
         mV <= '0;
      end else begin
         mV     <= {mV[L-2:0], goPipe};
         mQ[0]  <= divQ(dividendPipe, divisorPipe);
         mR[0]  <= divR(dividendPipe, divisorPipe);
         mNz[0] <= (divisorPipe != 16'd0);
         for (int k = 1; k < L; k++) begin
            mQ[k]  <= mQ[k-1];
            mR[k]  <= mR[k-1];
            mNz[k] <= mNz[k-1];
         end
      end
   end

   assign goResult            = mV[L-1] | forceGo;
   assign quotientResult      = mQ[L-1];
   assign remainderResult     = mR[L-1];
   assign divisorNoCeroResult = mNz[L-1];

   function automatic logic ackOf(int p);
      return (p != 0) ? ack1 : ack0;
   endfunction
   function automatic logic doneOf(int p);
      return (p != 0) ? done1 : done0;
   endfunction
   function automatic logic [15:0] qOf(int p);
      return (p != 0) ? quotient1 : quotient0;
   endfunction
   function automatic logic [15:0] rOf(int p);
      return (p != 0) ? remainder1 : remainder0;
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic setReq(int p, logic v, logic [31:0] dd, logic [15:0] dv);
      if (p != 0) begin req1 = v; dividend1 = dd; divisor1 = dv; end
      else begin req0 = v; dividend0 = dd; divisor0 = dv; end
   endtask

   task automatic dropReq(int p);
      if (p != 0) req1 = 1'b0;
      else req0 = 1'b0;
   endtask

   task automatic waitDone(int p, int budget, output int n);
      n = 0;
      while (!doneOf(p) && n < budget) begin
         tick();
         n++;
      end
   endtask

   task automatic readBoth();
      rd0 = 1'b1;
      rd1 = 1'b1;
      tick();
      rd0 = 1'b0;
      rd1 = 1'b0;
   endtask

   logic [31:0] tDd [4] = '{32'd21, -32'sd40, 32'd77, 32'd1000};
   logic [15:0] tDv [4] = '{16'd4, 16'd6, -16'sd8, 16'd3};
   logic [15:0] tQ  [4] = '{16'd5, 16'hFFFA, 16'hFFF7, 16'd333};
   logic [15:0] tR  [4] = '{16'd1, 16'hFFFC, 16'd5, 16'd1};

   initial begin
      int n;
      logic saw;
      reset = 1'b1; forceGo = 1'b0;
      req0 = 1'b0; req1 = 1'b0; rd0 = 1'b0; rd1 = 1'b0;
      divisor0 = '0; divisor1 = '0; dividend0 = '0; dividend1 = '0;
      tick();
      tick();
      req0 = 1'b1;
      #1;
      chk("ack0_in_reset", ack0, 0);
      chk("goPipe_reset", goPipe, 0);
      chk("done_reset", {done1, done0}, 0);
      chk("err_reset", err, 0);
      req0 = 1'b0;
      reset = 1'b0;
      tick();

      // Single operation 100 / 7
      setReq(0, 1, 32'd100, 16'd7);
      #1;
      chk("single_ack0", {ack1, ack0}, 2'b01);
      tick();
      dropReq(0);
      chk("single_goPipe", goPipe, 1);
      chk("single_divisorPipe", divisorPipe, 7);
      chk("single_dividendPipe", dividendPipe, 100);
      tick();
      chk("single_goPipe_low", goPipe, 0);
      waitDone(0, 60, n);
      chk("single_latency", n + 2, L + 2);
      chk("single_q", quotient0, 14);
      chk("single_r", remainder0, 2);
      chk("single_dz", divzero0, 0);
      rd0 = 1'b1;
      tick();
      rd0 = 1'b0;
      chk("single_rd_clears", done0, 0);
      chk("single_q_holds", quotient0, 14);

      // Contention right after reset
      reset = 1'b1;
      tick();
      reset = 1'b0;
      tick();
      setReq(0, 1, 32'd0, 16'd3);
      setReq(1, 1, 32'd50, 16'd5);
      #1;
      chk("cont_first", {ack1, ack0}, 2'b01);
      tick();
      dropReq(0);
      #1;
      chk("cont_second", {ack1, ack0}, 2'b10);
      tick();
      dropReq(1);
      waitDone(0, 60, n);
      chk("cont_lat0", n + 2, L + 2);
      chk("cont_q0r0", {quotient0, remainder0}, 0);
      chk("cont_done1_late", done1, 0);
      tick();
      chk("cont_done1", done1, 1);
      chk("cont_q1", quotient1, 10);
      chk("cont_r1", remainder1, 0);
      readBoth();

      // Pointer alternation: a solo grant to p must hand the next tie to the other port
      for (int r = 0; r < 4; r++) begin
         int p = r % 2;
         setReq(p, 1, tDd[r], tDv[r]);
         #1;
         chk("rr_solo_ack", ackOf(p), 1);
         tick();
         dropReq(p);
         waitDone(p, 60, n);
         chk("rr_solo_done", doneOf(p), 1);
         chk("rr_solo_q", qOf(p), tQ[r]);
         chk("rr_solo_r", rOf(p), tR[r]);
         readBoth();
         setReq(0, 1, tDd[r], tDv[r]);
         setReq(1, 1, tDd[r], tDv[r]);
         #1;
         chk("rr_tie_winner", {ackOf(1 - p), ackOf(p)}, 2'b10);
         tick();
         dropReq(1 - p);
         #1;
         chk("rr_tie_loser", ackOf(p), 1);
         tick();
         dropReq(p);
         waitDone(p, 60, n);
         chk("rr_tie_both_done", {done1, done0}, 2'b11);
         readBoth();
      end

      // Divide by zero on port 1
      setReq(1, 1, 32'd9, 16'd0);
      #1;
      chk("dz_ack1", ack1, 1);
      tick();
      dropReq(1);
      waitDone(1, 60, n);
      chk("dz_done1", done1, 1);
      chk("dz_flag1", divzero1, 1);
      chk("dz_done0_clear", done0, 0);
      readBoth();

      // Backpressure: unread result blocks a held request
      setReq(0, 1, 32'd100, 16'd7);
      tick();
      waitDone(0, 60, n);
      chk("bp_done0", done0, 1);
      saw = 1'b0;
      for (int c = 0; c < 20; c++) begin
         if (ack0) saw = 1'b1;
         tick();
      end
      chk("bp_no_ack", saw, 0);
      rd0 = 1'b1;
      tick();
      rd0 = 1'b0;
      #1;
      chk("bp_ack_after_rd", ack0, 1);
      tick();
      dropReq(0);
      waitDone(0, 60, n);
      chk("bp_second_done", done0, 1);
      readBoth();

      // Reset with both ports in flight
      setReq(0, 1, 32'd8, 16'd2);
      setReq(1, 1, 32'd8, 16'd4);
      tick();
      tick();
      dropReq(0);
      dropReq(1);
      tick();
      tick();
      reset = 1'b1;
      tick();
      reset = 1'b0;
      chk("rst_goPipe", goPipe, 0);
      chk("rst_done", {done1, done0}, 0);
      chk("rst_q0", quotient0, 0);
      chk("rst_r1", remainder1, 0);
      chk("rst_divisorPipe", divisorPipe, 0);
      saw = 1'b0;
      for (int c = 0; c < L + 6; c++) begin
         if (done0 || done1) saw = 1'b1;
         tick();
      end
      chk("rst_no_done", saw, 0);
      chk("rst_err", err, 0);
      setReq(0, 1, 32'd50, 16'd5);
      #1;
      chk("rst_new_ack", ack0, 1);
      tick();
      dropReq(0);
      waitDone(0, 60, n);
      chk("rst_new_lat", n + 1, L + 2);
      chk("rst_new_q", quotient0, 10);
      readBoth();

      // Result strobe with an empty tag register
      forceGo = 1'b1;
      tick();
      forceGo = 1'b0;
      chk("mis_err", err, 1);
      for (int c = 0; c < 5; c++) tick();
      chk("mis_err_sticky", err, 1);
      chk("mis_no_done", {done1, done0}, 0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule

// File: doc/div_pipe_arbiter.md
Name: div_pipe_arbiter

Overview:
Shares one pipelined signed divider between two requesters (port 0, port 1). Accepts operands through a req/ack handshake and arbitrates round-robin. Issues one operation per cycle into the divider's first stage via go/divisor/dividend. Tracks each operation's owner through a tag shift register matched to the pipeline depth, captures the results, and holds them per requester until read.

Parameters:
ANCHO_DV, 16, divisor width in bits
ANCHO_DD, 32, dividend width in bits
ANCHO_Q, 16, quotient and remainder width in bits
LATENCIA, 18, cycles from goPipe asserted to goResult asserted for the same operation (>=2)

Ports:
clk  in  1  clock, rising edge
reset  in  1  synchronous, active-high
req0 / req1  in  1  operation request; held until ack
divisor0 / divisor1  in  ANCHO_DV  signed divisor
dividend0 / dividend1  in  ANCHO_DD  signed dividend
ack0 / ack1  out  1  combinational one-cycle grant; operands sampled this cycle
done0 / done1  out  1  result held valid
quotient0 / quotient1  out  ANCHO_Q  captured quotient
remainder0 / remainder1  out  ANCHO_Q  captured remainder
divzero0 / divzero1  out  1  captured divide-by-zero flag
rd0 / rd1  in  1  result consumed; effective only while done
goPipe  out  1  registered issue strobe to divider stage 1
divisorPipe  out  ANCHO_DV  registered operand
dividendPipe  out  ANCHO_DD  registered operand
goResult  in  1  divider output valid
quotientResult  in  ANCHO_Q  divider quotient
remainderResult  in  ANCHO_Q  divider remainder
divisorNoCeroResult  in  1  divider non-zero-divisor flag
err  out  1  sticky tag/go misalignment flag

Behaviour:
- Reset (synchronous; clears everything regardless of state): all registered outputs are 0; tag shift register cleared; ptr=0; inflight0/1=0. ack is combinational and therefore 0 while reset is asserted.
- Eligibility: port i is eligible when req_i && !inflight_i && !done_i. Each port has at most one operation outstanding.
- Arbitration:
  - One eligible port: it is granted.
  - Both eligible: port ptr is granted.
  - After any grant to port i: ptr <= ~i. ptr is unchanged on cycles with no grant.
  - At most one ack per cycle.
- Issue, ack_i in cycle T:
  - At edge end of T: divisorPipe/dividendPipe <= port i operands; goPipe <= 1; inflight_i <= 1; tag entry {valid=1, id=i} enters the shift register.
  - goPipe is high for cycle T+1 only. It is 0 in any cycle without a preceding grant; operand registers hold their values.
- Tag shift register: LATENCIA entries of {valid, id}, advanced every cycle, so the head entry is aligned with goResult in cycle T+LATENCIA+1.
- Capture, head.valid && goResult in cycle T+LATENCIA+1:
  - At that edge: quotient/remainder of port head.id <= results; divzero <= ~divisorNoCeroResult; done <= 1; inflight <= 0.
  - done_i is first visible in cycle T+LATENCIA+2.
- Misalignment: if head.valid != goResult in a cycle, err <= 1 (sticky until reset).
  - Head valid without goResult: the owner's inflight clears; done stays 0.
  - goResult without a valid head: the result is discarded.
- Read: rd_i && done_i clears done_i at the edge. Result registers hold their values. Port i becomes eligible again the next cycle. rd_i while !done_i is ignored.
- Simultaneous events:
  - Capture for port a and grant for port b in the same cycle are independent.
  - A new grant for a port cannot coincide with its own capture (it is ineligible while inflight).
- Throughput: back-to-back grants alternate ports; at most 2 operations are ever in the pipeline.
- Divider overflow and sign handling belong to the divider. The controller passes values unchanged.

Test Plan:
- Single op: req0, dividend0=100, divisor0=7 → ack0 in the request cycle; goPipe 1 cycle later with divisorPipe=7, dividendPipe=100; done0 at LATENCIA+2 with quotient0=14, remainder0=2, divzero0=0; rd0 clears done0 one edge later.
- Contention: req0 and req1 together after reset (0/3 and 50/5) → ack0 first, ack1 next cycle; done0 (q=0, r=0) then done1 (q=10, r=0) on consecutive cycles; ptr alternation checked over 4 more rounds.
- Divide by zero: req1, divisor1=0, dividend1=9 → done1 with divzero1=1; done0 unaffected.
- Backpressure: done0 held with rd0=0 and req0 still high → no ack0 for 20 cycles; assert rd0 → ack0 exactly 1 cycle after the rd edge.
- Reset mid-flight: issue on both ports, assert reset at cycle 5 → all outputs 0, no done ever appears; a new req0 after reset completes normally.
- Misalignment: force goResult=1 with an empty tag register → err=1 and stays 1; no done asserted.
